sys_bus_interconnect: RTL and testbench
=======================================

Name: sys_bus_interconnect

Overview:
- Sits directly downstream of the AXI-to-sys-bus slave and consumes its simple sys bus (addr/wdata/sel/wen/ren in; rdata/err/ack out).
- Decodes the address into one of NUM_SLV regions and forwards a single-cycle strobe to that sub-block.
- Returns the registered ack, err and rdata from that sub-block to the slave.
- Handles one outstanding transaction; unpopulated regions and hung sub-blocks produce an error response.

Parameters:
- SYS_DW, 32, data width.
- SYS_AW, 32, address width.
- SYS_SW, SYS_DW>>3, byte-select width.
- NUM_SLV, 8, number of sub-bus regions (power of 2, 2..16).
- DEC_LSB, 20, lowest address bit of the region index field; field width is log2(NUM_SLV).
- SLV_EN, 8'hFF, populated-region mask, bit i = region i present.
- TIMEOUT, 63, ACCESS cycles before timeout error (6-bit counter, 1..63).

Ports:
- sys_clk_i  in  1  clock.
- sys_rstn_i  in  1  asynchronous active-low reset.
- sys_addr_i  in  SYS_AW  request address.
- sys_wdata_i  in  SYS_DW  write data.
- sys_sel_i  in  SYS_SW  byte selects.
- sys_wen_i  in  1  write request pulse.
- sys_ren_i  in  1  read request pulse.
- sys_rdata_o  out  SYS_DW  read data, valid with sys_ack_o.
- sys_err_o  out  1  error, valid with sys_ack_o.
- sys_ack_o  out  1  one-cycle completion pulse.
- sub_addr_o  out  SYS_AW  latched address (full width, broadcast to all regions).
- sub_wdata_o  out  SYS_DW  latched write data.
- sub_sel_o  out  SYS_SW  latched byte selects.
- sub_wen_o  out  NUM_SLV  per-region write strobe.
- sub_ren_o  out  NUM_SLV  per-region read strobe.
- sub_rdata_i  in  NUM_SLV*SYS_DW  per-region read data; region i occupies bits [i*SYS_DW +: SYS_DW].
- sub_err_i  in  NUM_SLV  per-region error.
- sub_ack_i  in  NUM_SLV  per-region ack.

Behaviour:
- Single clock sys_clk_i; asynchronous active-low reset sys_rstn_i.
- Reset values:
  - All outputs 0; state IDLE; timeout counter 0.
  - Reset mid-transaction drops the transaction: no ack is ever issued for it.
- State machine states: IDLE, ACCESS, RESP.
- IDLE:
  - On sys_wen_i or sys_ren_i: latch addr, wdata, sel, direction and region index idx = sys_addr_i[DEC_LSB +: log2(NUM_SLV)].
  - If SLV_EN[idx]=1: go to ACCESS.
  - If SLV_EN[idx]=0: go to RESP with err=1 and rdata=0; no strobe is issued.
- sys_wen_i and sys_ren_i asserted in the same cycle:
  - Illegal request; go to RESP with err=1 and rdata=0.
  - No strobe is issued.
- ACCESS:
  - Assert sub_wen_o[idx] or sub_ren_o[idx] in the first ACCESS cycle only, as a one-cycle pulse.
  - In every ACCESS cycle, including the strobe cycle (zero-wait sub-blocks), sample sub_ack_i[idx] | sub_err_i[idx].
  - On either: capture sub_rdata_i slice idx (read) or 0 (write), capture err = sub_err_i[idx], go to RESP.
  - Ack/err from any region other than idx is ignored.
- RESP:
  - sys_ack_o=1 for exactly one cycle, with sys_err_o and sys_rdata_o valid.
  - Go to IDLE.
  - sys_err_o and sys_rdata_o return to 0 in the following cycle.
- sub_addr_o, sub_wdata_o and sub_sel_o hold their latched values until the next accepted request.
- Requests arriving while not in IDLE are ignored; the upstream slave guarantees one outstanding request.
- Latency with a zero-wait sub-block: request at cycle 0, strobe at cycle 1, sys_ack_o at cycle 2.
- Each extra sub-block wait cycle adds 1 cycle.

Optional Feature:
- Macro name: SYS_BUS_TIMEOUT_EN.
- Defined:
  - The 6-bit counter clears on entering ACCESS and increments each ACCESS cycle without ack.
  - When the count reaches TIMEOUT, go to RESP with err=1 and rdata=0.
  - A sub-block ack arriving in the same cycle as the timeout wins: its normal response is used.
  - A late ack arriving after the timeout is ignored.
- Not defined:
  - No counter is synthesised.
  - ACCESS waits indefinitely for ack/err.

Test Plan:
- Write to region 2 (addr 0x0020_0010, wdata 0xDEADBEEF, sel 4'hF), sub 2 acks in the strobe cycle -> sub_wen_o=8'h04 for 1 cycle at cycle 1; sub_wdata_o=0xDEADBEEF; sys_ack_o=1, sys_err_o=0 at cycle 2.
- Read from region 5 (addr 0x0050_0000), sub 5 returns 0x12345678 with ack after 3 wait cycles -> sys_rdata_o=0x12345678 with sys_ack_o at cycle 5; ack from region 4 during the wait is ignored.
- SLV_EN=8'h7F, read from addr 0x0070_0000 -> no sub strobe; sys_ack_o=1, sys_err_o=1, sys_rdata_o=0 at cycle 2.
- Macro defined, TIMEOUT=63, read from region 1 with no ack -> sys_ack_o with sys_err_o=1 exactly 63 cycles after the strobe; a late sub ack afterwards produces no second sys_ack_o.
- sys_wen_i and sys_ren_i asserted together -> error ack at cycle 2, no sub strobe.
- Assert sys_rstn_i low during ACCESS -> all outputs 0 immediately; after release, a new write completes normally with no stale ack.

Source files
------------

// File: rtl/sys_bus_interconnect.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// sys_bus_interconnect : decodes the sys bus into NUM_SLV sub-block regions,
// one outstanding transaction. Optional hang timer: SYS_BUS_TIMEOUT_EN.
// Rev 1.0
// ============================================================================
module sys_bus_interconnect #(
  parameter int                 SYS_DW  = 32,
  parameter int                 SYS_AW  = 32,
  parameter int                 SYS_SW  = SYS_DW >> 3,
  parameter int                 NUM_SLV = 8,
  parameter int                 DEC_LSB = 20,
  parameter logic [NUM_SLV-1:0] SLV_EN  = {NUM_SLV{1'b1}},
  parameter int                 TIMEOUT = 63
) (
  input  logic                      sys_clk_i,
  input  logic                      sys_rstn_i,
  input  logic [SYS_AW-1:0]         sys_addr_i,
  input  logic [SYS_DW-1:0]         sys_wdata_i,
  input  logic [SYS_SW-1:0]         sys_sel_i,
  input  logic                      sys_wen_i,
  input  logic                      sys_ren_i,
  output logic [SYS_DW-1:0]         sys_rdata_o,
  output logic                      sys_err_o,
  output logic                      sys_ack_o,
  output logic [SYS_AW-1:0]         sub_addr_o,
  output logic [SYS_DW-1:0]         sub_wdata_o,
  output logic [SYS_SW-1:0]         sub_sel_o,
  output logic [NUM_SLV-1:0]        sub_wen_o,
  output logic [NUM_SLV-1:0]        sub_ren_o,
  input  logic [NUM_SLV*SYS_DW-1:0] sub_rdata_i,
  input  logic [NUM_SLV-1:0]        sub_err_i,
  input  logic [NUM_SLV-1:0]        sub_ack_i
);

  localparam int              IDX_W     = $clog2(NUM_SLV);
  localparam logic [5:0]      C_TO_LAST = 6'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_idx, w_idx_nxt;
  logic               r_write, w_write_nxt;
  logic               r_fault, w_fault_nxt;
  logic [SYS_AW-1:0]  r_addr, w_addr_nxt;
  logic [SYS_DW-1:0]  r_wdata, w_wdata_nxt;
  logic [SYS_SW-1:0]  r_sel, w_sel_nxt;
  logic [NUM_SLV-1:0] r_wen_strb, w_wen_strb_nxt;
  logic [NUM_SLV-1:0] r_ren_strb, w_ren_strb_nxt;
  logic               r_ack, w_ack_nxt;
  logic               r_err, w_err_nxt;
  logic [SYS_DW-1:0]  r_rdata, w_rdata_nxt;

  logic [SYS_DW-1:0]  w_rdata_arr [NUM_SLV];
  logic [IDX_W-1:0]   w_req_idx;
  logic               w_hit;
  logic               w_timeout;

  for (genvar i = 0; i < NUM_SLV; i++) begin : g_slice
    assign w_rdata_arr[i] = sub_rdata_i[i*SYS_DW +: SYS_DW];
  end

  assign w_req_idx = sys_addr_i[DEC_LSB +: IDX_W];
  assign w_hit     = sub_ack_i[r_idx] | sub_err_i[r_idx];

`ifdef SYS_BUS_TIMEOUT_EN
  logic [5:0] r_to_cnt;

  // Held at zero outside ACCESS, so it always starts from zero on entry.
  always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
    if (!sys_rstn_i)              r_to_cnt <= '0;
    else if (r_state != ST_ACCESS) r_to_cnt <= '0;
    else                          r_to_cnt <= r_to_cnt + 6'd1;
  end

  assign w_timeout = (r_to_cnt == C_TO_LAST);
`else
  // Timer compiled out; the term only keeps TIMEOUT referenced.
  assign w_timeout = 1'b0 & (C_TO_LAST == 6'h3F);
`endif

  always_comb begin
    w_state_nxt    = r_state;
    w_idx_nxt      = r_idx;
    w_write_nxt    = r_write;
    w_fault_nxt    = r_fault;
    w_addr_nxt     = r_addr;
    w_wdata_nxt    = r_wdata;
    w_sel_nxt      = r_sel;
    w_wen_strb_nxt = '0;
    w_ren_strb_nxt = '0;
    w_ack_nxt      = 1'b0;
    w_err_nxt      = 1'b0;
    w_rdata_nxt    = '0;

    case (r_state)
      ST_IDLE: begin
        if (sys_wen_i || sys_ren_i) begin
          w_addr_nxt  = sys_addr_i;
          w_wdata_nxt = sys_wdata_i;
          w_sel_nxt   = sys_sel_i;
          w_write_nxt = sys_wen_i;
          w_idx_nxt   = w_req_idx;
          w_fault_nxt = (sys_wen_i && sys_ren_i) || !SLV_EN[w_req_idx];
          // Rejected requests still pass through ACCESS (strobe-less) so
          // every response arrives with the same two-cycle latency.
          w_state_nxt = ST_ACCESS;
          if (!w_fault_nxt) begin
            w_wen_strb_nxt[w_req_idx] = sys_wen_i;
            w_ren_strb_nxt[w_req_idx] = sys_ren_i;
          end
        end
      end
      ST_ACCESS: begin
        if (r_fault) begin
          w_state_nxt = ST_RESP;
          w_ack_nxt   = 1'b1;
          w_err_nxt   = 1'b1;
        end else if (w_hit) begin
          w_state_nxt = ST_RESP;
          w_ack_nxt   = 1'b1;
          w_err_nxt   = sub_err_i[r_idx];
          w_rdata_nxt = r_write ? '0 : w_rdata_arr[r_idx];
        end else if (w_timeout) begin
          w_state_nxt = ST_RESP;
          w_ack_nxt   = 1'b1;
          w_err_nxt   = 1'b1;
        end
      end
      ST_RESP:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
    if (!sys_rstn_i) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_write    <= 1'b0;
      r_fault    <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_sel      <= '0;
      r_wen_strb <= '0;
      r_ren_strb <= '0;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_rdata    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_write    <= w_write_nxt;
      r_fault    <= w_fault_nxt;
      r_addr     <= w_addr_nxt;
      r_wdata    <= w_wdata_nxt;
      r_sel      <= w_sel_nxt;
      r_wen_strb <= w_wen_strb_nxt;
      r_ren_strb <= w_ren_strb_nxt;
      r_ack      <= w_ack_nxt;
      r_err      <= w_err_nxt;
      r_rdata    <= w_rdata_nxt;
    end
  end

  assign sys_ack_o   = r_ack;
  assign sys_err_o   = r_err;
  assign sys_rdata_o = r_rdata;
  assign sub_addr_o  = r_addr;
  assign sub_wdata_o = r_wdata;
  assign sub_sel_o   = r_sel;
  assign sub_wen_o   = r_wen_strb;
  assign sub_ren_o   = r_ren_strb;

endmodule
`default_nettype wire

// File: tb/tb_sys_bus_interconnect.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_sys_bus_interconnect : directed + randomized transactions against a
// cycle-level transaction model of the interconnect.
// Rev 1.0
// ============================================================================
module tb_sys_bus_interconnect;

  localparam logic [7:0] SLV_EN_TB = 8'h7F;
`ifdef SYS_BUS_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [31:0]  sys_addr = '0;
  logic [31:0]  sys_wdata = '0;
  logic [3:0]   sys_sel = '0;
  logic         sys_wen = 1'b0;
  logic         sys_ren = 1'b0;
  logic [31:0]  sys_rdata;
  logic         sys_err;
  logic         sys_ack;
  logic [31:0]  sub_addr;
  logic [31:0]  sub_wdata;
  logic [3:0]   sub_sel;
  logic [7:0]   sub_wen;
  logic [7:0]   sub_ren;
  logic [255:0] sub_rdata = '0;
  logic [7:0]   sub_err = '0;
  logic [7:0]   sub_ack = '0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sys_bus_interconnect #(
    .SYS_DW(32), .SYS_AW(32), .SYS_SW(4), .NUM_SLV(8), .DEC_LSB(20),
    .SLV_EN(SLV_EN_TB), .TIMEOUT(63)
  ) dut (
    .sys_clk_i(clk), .sys_rstn_i(rst_n),
    .sys_addr_i(sys_addr), .sys_wdata_i(sys_wdata), .sys_sel_i(sys_sel),
    .sys_wen_i(sys_wen), .sys_ren_i(sys_ren),
    .sys_rdata_o(sys_rdata), .sys_err_o(sys_err), .sys_ack_o(sys_ack),
    .sub_addr_o(sub_addr), .sub_wdata_o(sub_wdata), .sub_sel_o(sub_sel),
    .sub_wen_o(sub_wen), .sub_ren_o(sub_ren),
    .sub_rdata_i(sub_rdata), .sub_err_i(sub_err), .sub_ack_i(sub_ack)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ack"},   64'(sys_ack),   64'h0);
    check({tag, "_err"},   64'(sys_err),   64'h0);
    check({tag, "_rdata"}, 64'(sys_rdata), 64'h0);
    check({tag, "_saddr"}, 64'(sub_addr),  64'h0);
    check({tag, "_swdat"}, 64'(sub_wdata), 64'h0);
    check({tag, "_ssel"},  64'(sub_sel),   64'h0);
    check({tag, "_swen"},  64'(sub_wen),   64'h0);
    check({tag, "_sren"},  64'(sub_ren),   64'h0);
  endtask

  // One transaction. delay = sub-block wait cycles after the strobe cycle
  // (negative = never answers); noise = acks/errs on other regions.
  task automatic run_txn(input logic wen, input logic ren, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] sel,
                         input logic [31:0] rd_val, input int delay,
                         input logic serr, input logic [7:0] noise);
    logic [7:0]  en = SLV_EN_TB;
    int          idx = int'(addr[22:20]);
    logic [7:0]  onehot = 8'(1) << idx;
    logic        fault = (wen && ren) || !en[idx];
    int          ack_cyc;
    logic        exp_err;
    logic [31:0] exp_rd;

    if (fault) begin
      ack_cyc = 2; exp_err = 1'b1; exp_rd = '0;
    end else if (TO_EN && (delay < 0 || delay > 62)) begin
      ack_cyc = 64; exp_err = 1'b1; exp_rd = '0;
    end else begin
      ack_cyc = 2 + delay; exp_err = serr; exp_rd = wen ? 32'h0 : rd_val;
    end

    @(posedge clk); #1;
    sys_addr = addr; sys_wdata = wdata; sys_sel = sel;
    sys_wen = wen;   sys_ren = ren;
    for (int i = 0; i < 8; i++) sub_rdata[i*32 +: 32] = $urandom;
    sub_rdata[idx*32 +: 32] = rd_val;

    @(posedge clk); #1;
    sys_wen = 1'b0; sys_ren = 1'b0;
    sys_addr = $urandom; sys_wdata = $urandom; sys_sel = 4'($urandom);
    check("strobe_wen", 64'(sub_wen), 64'((!fault && wen) ? onehot : 8'h0));
    check("strobe_ren", 64'(sub_ren), 64'((!fault && ren) ? onehot : 8'h0));
    check("sub_addr",   64'(sub_addr),  64'(addr));
    check("sub_wdata",  64'(sub_wdata), 64'(wdata));
    check("sub_sel",    64'(sub_sel),   64'(sel));

    for (int k = 1; k <= ack_cyc; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      sub_ack = noise & ~onehot;
      sub_err = noise & ~onehot & 8'($urandom);
      if (!fault && delay >= 0 && k == 1 + delay) begin
        if (serr) sub_err[idx] = 1'b1;
        else      sub_ack[idx] = 1'b1;
      end
      if (k > 1) begin
        check("strobe_off", 64'({sub_wen, sub_ren}), 64'h0);
      end
      check("sys_ack", 64'(sys_ack), 64'(k == ack_cyc));
    end
    check("sys_err",   64'(sys_err),   64'(exp_err));
    check("sys_rdata", 64'(sys_rdata), 64'(exp_rd));

    @(posedge clk); #1;
    sub_ack = '0; sub_err = '0;
    check("post_ack",   64'(sys_ack),   64'h0);
    check("post_err",   64'(sys_err),   64'h0);
    check("post_rdata", 64'(sys_rdata), 64'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    #2;
    check_all_zero("reset");
    #20; rst_n = 1'b1;

    // Zero-wait write, region 2
    run_txn(1'b1, 1'b0, 32'h0020_0010, 32'hDEAD_BEEF, 4'hF, 32'h0, 0, 1'b0, 8'h00);
    // Read region 5, three wait cycles, region 4 acking meanwhile
    run_txn(1'b0, 1'b1, 32'h0050_0000, 32'h0, 4'hF, 32'h1234_5678, 3, 1'b0, 8'h10);
    // Unpopulated region 7
    run_txn(1'b0, 1'b1, 32'h0070_0000, 32'h0, 4'hF, 32'hCAFE_F00D, 0, 1'b0, 8'h00);
    // Write and read together
    run_txn(1'b1, 1'b1, 32'h0020_0000, 32'h5555_AAAA, 4'h3, 32'h0, 0, 1'b0, 8'h00);
    // Sub-block error on a read still returns its data
    run_txn(1'b0, 1'b1, 32'h0010_0008, 32'h0, 4'hF, 32'hA5A5_0001, 1, 1'b1, 8'h00);
    // Ack on the last possible cycle before a timeout
    run_txn(1'b0, 1'b1, 32'h0010_0000, 32'h0, 4'hF, 32'h0BAD_CAFE, 62, 1'b0, 8'h00);

    // Hung sub-block, then a late ack that must not re-trigger a response
    if (TO_EN) run_txn(1'b0, 1'b1, 32'h0010_0000, 32'h0, 4'hF, 32'h1111_2222, -1, 1'b0, 8'h00);
    else       run_txn(1'b0, 1'b1, 32'h0010_0000, 32'h0, 4'hF, 32'h1111_2222, 80, 1'b0, 8'h00);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      sub_ack = 8'h02;
      check("late_ack", 64'(sys_ack), 64'h0);
    end
    sub_ack = '0;

    // Randomized traffic
    for (int t = 0; t < 40; t++) begin
      int          r = $urandom_range(0, 9);
      logic        w = (r == 0) || (r >= 1 && r <= 4);
      logic        rd = (r == 0) || (r >= 5);
      run_txn(w, rd, $urandom, $urandom, 4'($urandom), $urandom,
              $urandom_range(0, 4), ($urandom_range(0, 5) == 0), 8'($urandom));
    end

    // Reset in the middle of an ACCESS
    @(posedge clk); #1;
    sys_addr = 32'h0030_0004; sys_wdata = 32'h7777_8888; sys_sel = 4'hF; sys_ren = 1'b1;
    @(posedge clk); #1;
    sys_ren = 1'b0;
    check("rst_pre_strobe", 64'(sub_ren), 64'h08);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_mid");
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sub_ack = 8'h08;
      @(posedge clk); #1;
      check("stale_ack", 64'(sys_ack), 64'h0);
    end
    sub_ack = '0;
    run_txn(1'b1, 1'b0, 32'h0020_0010, 32'h0123_4567, 4'hC, 32'h0, 1, 1'b0, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
